// File: rtl/issue_queue_gen.sv
// Parametrised out-of-order issue queue: tag wakeup, age-matrix oldest-ready select per port.
// Optional feature macro IQ_GEN_PERF_EN adds saturating perf_issued / perf_full_cycles counters.
module issue_queue_gen #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DISPATCH_W = 4,
  parameter int unsigned ISSUE_W    = 3,
  parameter int unsigned NSRC       = 3,
  parameter int unsigned TAG_W      = 6,
  parameter int unsigned FU_W       = 4,
  parameter int unsigned PAYLOAD_W  = 128,
  parameter int unsigned WAKE_W     = 4,
  parameter logic [ISSUE_W*(2**FU_W)-1:0] PORT_FU_MASK = 48'h0004_000A_0009
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             flush,
  input  logic [DISPATCH_W-1:0]            in_valid,
  input  logic [DISPATCH_W*FU_W-1:0]       in_fu,
  input  logic [DISPATCH_W*NSRC*TAG_W-1:0] in_src_tag,
  input  logic [DISPATCH_W*NSRC-1:0]       in_src_rdy,
  input  logic [DISPATCH_W*PAYLOAD_W-1:0]  in_payload,
  input  logic [WAKE_W-1:0]                wake_valid,
  input  logic [WAKE_W*TAG_W-1:0]          wake_tag,
  input  logic [ISSUE_W-1:0]               port_busy,
  output logic [ISSUE_W-1:0]               issue_valid,
  output logic [ISSUE_W*PAYLOAD_W-1:0]     issue_payload,
  output logic                             full
`ifdef IQ_GEN_PERF_EN
  ,
  output logic [31:0]                      perf_issued,
  output logic [31:0]                      perf_full_cycles
`endif
);

  localparam int unsigned NFU   = 2**FU_W;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [ISSUE_W-1:0][NFU-1:0] FU_MASK = PORT_FU_MASK;

  // elder_q[s][j] = 1 when entry j is older than entry s
  logic [DEPTH-1:0]                        valid_q, valid_d;
  logic [DEPTH-1:0][DEPTH-1:0]             elder_q, elder_d;
  logic [DEPTH-1:0][NSRC-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [DEPTH-1:0][NSRC-1:0]              rdy_q, rdy_d;
  logic [DEPTH-1:0][FU_W-1:0]              fu_q, fu_d;
  logic [DEPTH-1:0][PAYLOAD_W-1:0]         pay_q, pay_d;
  logic [CNT_W-1:0]                        free_q, free_d;
  logic                                    full_q;

  logic                                    enq_ok;
  logic [DISPATCH_W-1:0]                   alloc_en;
  logic [DISPATCH_W-1:0][IDX_W-1:0]        alloc_slot;
  logic [DEPTH-1:0]                        alloc_taken;
  logic [DEPTH-1:0]                        eligible;
  logic [DEPTH-1:0]                        picked;
  logic [ISSUE_W-1:0][DEPTH-1:0]           cand;
  logic [ISSUE_W-1:0]                      sel_hit;
  logic [ISSUE_W-1:0][IDX_W-1:0]           sel_idx;
  logic [CNT_W-1:0]                        n_iss, n_enq;

  function automatic logic wake_hit(input logic [TAG_W-1:0] tag,
                                    input logic [WAKE_W-1:0] wv,
                                    input logic [WAKE_W*TAG_W-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WAKE_W; w++) begin
      if (wv[w] && (wt[w*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign enq_ok = ~full_q & ~flush;
  assign full   = full_q;

  // Lane-ordered allocation of the lowest free slot; slots issuing this cycle stay taken.
  always_comb begin
    alloc_taken = valid_q;
    alloc_en    = '0;
    alloc_slot  = '0;
    for (int i = 0; i < DISPATCH_W; i++) begin
      if (enq_ok && in_valid[i]) begin
        for (int j = int'(DEPTH) - 1; j >= 0; j--) begin
          if (!alloc_taken[j]) begin
            alloc_en[i]   = 1'b1;
            alloc_slot[i] = IDX_W'(j);
          end
        end
        if (alloc_en[i]) alloc_taken[alloc_slot[i]] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      eligible[r] = valid_q[r] & (&rdy_q[r]);
    end
  end

  // Per-port oldest-eligible select; lower ports claim entries first.
  always_comb begin
    picked        = '0;
    cand          = '0;
    sel_hit       = '0;
    sel_idx       = '0;
    issue_valid   = '0;
    issue_payload = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        cand[p][i] = eligible[i] & FU_MASK[p][fu_q[i]] & ~picked[i];
      end
      if (!port_busy[p]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cand[p][i] && ((cand[p] & elder_q[i]) == '0)) begin
            sel_hit[p] = 1'b1;
            sel_idx[p] = IDX_W'(i);
          end
        end
      end
      if (sel_hit[p]) begin
        picked[sel_idx[p]]                          = 1'b1;
        issue_valid[p]                              = 1'b1;
        issue_payload[p*PAYLOAD_W +: PAYLOAD_W]     = pay_q[sel_idx[p]];
      end
    end
  end

  always_comb begin
    n_iss = '0;
    n_enq = '0;
    for (int p = 0; p < ISSUE_W; p++) n_iss = n_iss + CNT_W'(issue_valid[p]);
    for (int i = 0; i < DISPATCH_W; i++) n_enq = n_enq + CNT_W'(alloc_en[i]);
  end

  // Next state: wakeup, enqueue, age update, retire and flush.
  always_comb begin
    valid_d = valid_q & ~picked;
    elder_d = elder_q;
    tag_d   = tag_q;
    rdy_d   = rdy_q;
    fu_d    = fu_q;
    pay_d   = pay_q;
    for (int r = 0; r < DEPTH; r++) begin
      for (int k = 0; k < NSRC; k++) begin
        if (valid_q[r] && wake_hit(tag_q[r][k], wake_valid, wake_tag)) rdy_d[r][k] = 1'b1;
      end
    end
    for (int i = 0; i < DISPATCH_W; i++) begin
      if (alloc_en[i]) begin
        for (int r = 0; r < DEPTH; r++) elder_d[r][alloc_slot[i]] = 1'b0;
        elder_d[alloc_slot[i]] = valid_q;
        for (int l = 0; l < i; l++) begin
          if (alloc_en[l]) elder_d[alloc_slot[i]][alloc_slot[l]] = 1'b1;
        end
        valid_d[alloc_slot[i]] = 1'b1;
        fu_d[alloc_slot[i]]    = in_fu[i*FU_W +: FU_W];
        pay_d[alloc_slot[i]]   = in_payload[i*PAYLOAD_W +: PAYLOAD_W];
        for (int k = 0; k < NSRC; k++) begin
          tag_d[alloc_slot[i]][k] = in_src_tag[(i*NSRC+k)*TAG_W +: TAG_W];
          rdy_d[alloc_slot[i]][k] = in_src_rdy[i*NSRC+k] |
              wake_hit(in_src_tag[(i*NSRC+k)*TAG_W +: TAG_W], wake_valid, wake_tag);
        end
      end
    end
    free_d = free_q + n_iss - n_enq;
    if (flush) begin
      valid_d = '0;
      free_d  = CNT_W'(DEPTH);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q <= '0;
      elder_q <= '0;
      free_q  <= CNT_W'(DEPTH);
      full_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      elder_q <= elder_d;
      free_q  <= free_d;
      full_q  <= (free_d < CNT_W'(DISPATCH_W));
    end
  end

  // Entry contents are qualified by valid_q and need no reset.
  always_ff @(posedge clock) begin
    tag_q <= tag_d;
    rdy_q <= rdy_d;
    fu_q  <= fu_d;
    pay_q <= pay_d;
  end

`ifdef IQ_GEN_PERF_EN
  logic [31:0] perf_issued_q, perf_full_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      perf_issued_q <= '0;
      perf_full_q   <= '0;
    end else begin
      if (perf_issued_q <= (32'hFFFF_FFFF - 32'(n_iss))) perf_issued_q <= perf_issued_q + 32'(n_iss);
      else                                                perf_issued_q <= 32'hFFFF_FFFF;
      if (full_q && (perf_full_q != 32'hFFFF_FFFF)) perf_full_q <= perf_full_q + 32'd1;
    end
  end

  assign perf_issued      = perf_issued_q;
  assign perf_full_cycles = perf_full_q;
`endif

endmodule

// File: tb/tb_issue_queue_gen.sv
// Directed table-driven bench for issue_queue_gen (default parameters, perf counters disabled).
module tb_issue_queue_gen;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          flush;
  logic [3:0]    in_valid;
  logic [15:0]   in_fu;
  logic [71:0]   in_src_tag;
  logic [11:0]   in_src_rdy;
  logic [511:0]  in_payload;
  logic [3:0]    wake_valid;
  logic [23:0]   wake_tag;
  logic [2:0]    port_busy;
  logic [2:0]    issue_valid;
  logic [383:0]  issue_payload;
  logic          full;

  issue_queue_gen dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_fu         (in_fu),
    .in_src_tag    (in_src_tag),
    .in_src_rdy    (in_src_rdy),
    .in_payload    (in_payload),
    .wake_valid    (wake_valid),
    .wake_tag      (wake_tag),
    .port_busy     (port_busy),
    .issue_valid   (issue_valid),
    .issue_payload (issue_payload),
    .full          (full)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic             flush;
    logic [3:0]       vld;
    logic [15:0]      fu;
    logic [11:0]      rdy;
    logic [5:0]       tag;
    logic [15:0]      pid;
    logic             wv;
    logic [1:0]       wl;
    logic [5:0]       wt;
    logic [2:0]       busy;
    logic [2:0]       e_iv;
    logic [2:0][15:0] e_p;
    logic             e_full;
  } vec_t;

  vec_t vq[$];
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic row(input logic fl, input logic [3:0] vld, input logic [15:0] fu,
                     input logic [11:0] rdy, input logic [5:0] tag, input logic [15:0] pid,
                     input logic wv, input logic [1:0] wl, input logic [5:0] wt,
                     input logic [2:0] busy, input logic [2:0] iv,
                     input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                     input logic ef);
    vec_t v;
    v.flush = fl; v.vld = vld; v.fu = fu; v.rdy = rdy; v.tag = tag; v.pid = pid;
    v.wv = wv; v.wl = wl; v.wt = wt; v.busy = busy;
    v.e_iv = iv; v.e_p = {p2, p1, p0}; v.e_full = ef;
    vq.push_back(v);
  endtask

  task automatic idl(input logic [2:0] busy, input logic [2:0] iv,
                     input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                     input logic ef);
    row(1'b0, 4'h0, 16'h0, 12'hFFF, 6'd0, 16'h0, 1'b0, 2'd0, 6'd0, busy, iv, p0, p1, p2, ef);
  endtask

  task automatic drive(input vec_t v);
    flush      = v.flush;
    in_valid   = v.vld;
    in_fu      = v.fu;
    in_src_rdy = v.rdy;
    for (int i = 0; i < 12; i++) in_src_tag[i*6 +: 6] = v.tag;
    for (int i = 0; i < 4; i++) in_payload[i*128 +: 128] = 128'(v.pid + 16'(i));
    wake_valid = '0;
    wake_tag   = '0;
    if (v.wv) begin
      wake_valid[v.wl]        = 1'b1;
      wake_tag[v.wl*6 +: 6]   = v.wt;
    end
    port_busy = v.busy;
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, " issue_valid"}, 128'(issue_valid), 128'(v.e_iv));
    check({tag, " full"}, 128'(full), 128'(v.e_full));
    for (int p = 0; p < 3; p++) begin
      if (v.e_iv[p]) check($sformatf("%s payload%0d", tag, p),
                           issue_payload[p*128 +: 128], 128'(v.e_p[p]));
    end
  endtask

  initial begin
    vec_t idle_v;
    // fill 4, single port drains oldest first
    row(0, 4'hF, 16'h0000, 12'hFFF, 0, 16'h100, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
    idl(3'b000, 3'b001, 16'h100, 0, 0, 0);
    idl(3'b000, 3'b001, 16'h101, 0, 0, 0);
    idl(3'b000, 3'b001, 16'h102, 0, 0, 0);
    idl(3'b000, 3'b001, 16'h103, 0, 0, 0);
    // mixed FU classes steered to ports
    row(0, 4'hF, 16'h3210, 12'hFFF, 0, 16'h200, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
    idl(3'b000, 3'b111, 16'h200, 16'h201, 16'h202, 0);
    idl(3'b000, 3'b001, 16'h203, 0, 0, 0);
    // A waits on tag 5, younger ready B bypasses it
    row(0, 4'h1, 16'h0000, 12'hFFE, 5, 16'h300, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
    row(0, 4'h1, 16'h0000, 12'hFFF, 5, 16'h310, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
    row(0, 4'h0, 16'h0000, 12'hFFF, 0, 16'h0,   1, 3, 6, 3'b000, 3'b001, 16'h310, 0, 0, 0);
    row(0, 4'h0, 16'h0000, 12'hFFF, 0, 16'h0,   1, 1, 5, 3'b000, 3'b000, 0, 0, 0, 0);
    idl(3'b000, 3'b001, 16'h300, 0, 0, 0);
    // same-cycle enqueue and wakeup
    row(0, 4'h1, 16'h0000, 12'hFFE, 7, 16'h400, 1, 2, 7, 3'b000, 3'b000, 0, 0, 0, 0);
    idl(3'b000, 3'b001, 16'h400, 0, 0, 0);
    // busy port holds entries
    row(0, 4'h3, 16'h0000, 12'hFFF, 0, 16'h500, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
    idl(3'b001, 3'b000, 0, 0, 0, 0);
    idl(3'b001, 3'b000, 0, 0, 0, 0);
    idl(3'b000, 3'b001, 16'h500, 0, 0, 0);
    idl(3'b000, 3'b001, 16'h501, 0, 0, 0);
    // fill 13 -> full, dropped enqueue, issue one -> not full, flush in issue cycle
    row(0, 4'hF, 16'h0000, 12'hFFF, 0, 16'h600, 0, 0, 0, 3'b111, 3'b000, 0, 0, 0, 0);
    row(0, 4'hF, 16'h0000, 12'hFFF, 0, 16'h610, 0, 0, 0, 3'b111, 3'b000, 0, 0, 0, 0);
    row(0, 4'hF, 16'h0000, 12'hFFF, 0, 16'h620, 0, 0, 0, 3'b111, 3'b000, 0, 0, 0, 0);
    row(0, 4'h1, 16'h0000, 12'hFFF, 0, 16'h630, 0, 0, 0, 3'b111, 3'b000, 0, 0, 0, 0);
    row(0, 4'hF, 16'h0000, 12'hFFF, 0, 16'h640, 0, 0, 0, 3'b111, 3'b000, 0, 0, 0, 1);
    idl(3'b110, 3'b001, 16'h600, 0, 0, 1);
    idl(3'b111, 3'b000, 0, 0, 0, 0);
    row(1, 4'hF, 16'h0000, 12'hFFF, 0, 16'h660, 0, 0, 0, 3'b110, 3'b001, 16'h601, 0, 0, 0);
    // 8 entries then flush, refill lands cleanly
    row(0, 4'hF, 16'h1111, 12'hFFF, 0, 16'h700, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
    row(0, 4'hF, 16'h1111, 12'hFFF, 0, 16'h710, 0, 0, 0, 3'b111, 3'b000, 0, 0, 0, 0);
    row(1, 4'h0, 16'h0000, 12'hFFF, 0, 16'h0,   0, 0, 0, 3'b000, 3'b010, 0, 16'h700, 0, 0);
    row(0, 4'hF, 16'h2222, 12'hFFF, 0, 16'h800, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
    idl(3'b000, 3'b100, 0, 0, 16'h800, 0);
    idl(3'b000, 3'b100, 0, 0, 16'h801, 0);
    idl(3'b000, 3'b100, 0, 0, 16'h802, 0);
    idl(3'b000, 3'b100, 0, 0, 16'h803, 0);
    // younger entry reusing a lower slot must not jump ahead
    row(0, 4'h3, 16'h0000, 12'hFFF, 0, 16'h900, 0, 0, 0, 3'b001, 3'b000, 0, 0, 0, 0);
    idl(3'b000, 3'b001, 16'h900, 0, 0, 0);
    row(0, 4'h1, 16'h0000, 12'hFFF, 0, 16'h910, 0, 0, 0, 3'b001, 3'b000, 0, 0, 0, 0);
    idl(3'b000, 3'b001, 16'h901, 0, 0, 0);
    idl(3'b000, 3'b001, 16'h910, 0, 0, 0);
    idl(3'b000, 3'b000, 0, 0, 0, 0);

    idle_v = '{flush: 1'b0, vld: 4'h0, fu: 16'h0, rdy: 12'hFFF, tag: 6'd0, pid: 16'h0,
               wv: 1'b0, wl: 2'd0, wt: 6'd0, busy: 3'b000, e_iv: 3'b000, e_p: '0, e_full: 1'b0};

    reset_n = 1'b0;
    drive(idle_v);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("reset issue_valid", 128'(issue_valid), 128'(3'b000));
    check("reset full", 128'(full), 128'(1'b0));

    for (int k = 0; k < vq.size(); k++) begin
      @(posedge clock);
      #1 drive(vq[k]);
      @(negedge clock);
      check_vec($sformatf("v%0d", k), vq[k]);
    end

    // fill all 16 slots, then a mid-run reset empties the queue
    for (int c = 0; c < 4; c++) begin
      vec_t f;
      f = idle_v;
      f.vld  = 4'hF;
      f.busy = 3'b111;
      f.pid  = 16'hA00 + 16'(c*4);
      @(posedge clock);
      #1 drive(f);
    end
    @(posedge clock);
    #1 begin
      drive(idle_v);
      port_busy = 3'b111;
    end
    @(negedge clock);
    check("filled full", 128'(full), 128'(1'b1));
    check("filled issue_valid", 128'(issue_valid), 128'(3'b000));
    reset_n = 1'b0;
    port_busy = 3'b000;
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rerst issue_valid", 128'(issue_valid), 128'(3'b000));
    check("rerst full", 128'(full), 128'(1'b0));
    @(posedge clock);
    @(negedge clock);
    check("rerst empty", 128'(issue_valid), 128'(3'b000));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
